// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, owner codes,
// transfer size codes and the latched bus command payload.
// Compile-time option: ARB_ROUND_ROBIN_EN (see mem_arbiter.sv).
package mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arbState_t;

  typedef logic owner_t;
  localparam owner_t OWN_INST = 1'b0;
  localparam owner_t OWN_DATA = 1'b1;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  // Payload captured at grant time; the address is kept separately because
  // its width is a module parameter.
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wdata;
  } busCmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction, data and bus handshake signals around the arbiter.
// Modports:
//   master - the arbiter itself (masters the shared bus, answers requesters)
//   slave  - the environment: instruction/data requesters and the bus slave
// Parameter ADDR_W: width of every address signal.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);

  // instruction port
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // data port
  logic              data_req;
  logic              data_wr;
  logic [SIZE_W-1:0] data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // shared bus
  logic              bus_req;
  logic              bus_wr;
  logic [SIZE_W-1:0] bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational grant selection between instruction and data requests.
// Ports:
//   instReq, dataReq - pending requests
//   lastOwner        - owner of the previous grant (only used with ARB_ROUND_ROBIN_EN)
//   grantValid       - at least one request pending
//   grantOwner       - OWN_INST or OWN_DATA
// Without ARB_ROUND_ROBIN_EN data always wins a conflict; with it the port that
// did not win last time wins.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   instReq,
  input  logic   dataReq,
  input  owner_t lastOwner,
  output logic   grantValid,
  output owner_t grantOwner
);

  always_comb begin
    grantValid = instReq | dataReq;
    grantOwner = OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
    if (instReq && dataReq) begin
      grantOwner = (lastOwner == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (dataReq) begin
      grantOwner = OWN_DATA;
    end
`else
    if (dataReq) begin
      grantOwner = OWN_DATA;
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  // fixed priority ignores history
  logic unusedLastOwner;
  assign unusedLastOwner = lastOwner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between an instruction and a data port,
// one outstanding bus transaction at a time (IDLE -> ADDR -> WAIT -> IDLE).
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   arbIf - instruction/data/bus handshake bundle (mem_arbiter_if.master)
//   busy  - high while a transaction is in flight (pipeline stall source)
// Option: define ARB_ROUND_ROBIN_EN to alternate grants on conflicts instead of
// fixed data-over-instruction priority.
// The *_addr_ok / *_data_ok / *_rdata responses are combinational from the bus
// handshakes so the owner sees completion in the same cycle as the bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
)(
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.master       arbIf,
  output logic                busy
);

  arbState_t         state;
  owner_t            owner;
  busCmd_t           latCmd;
  logic [ADDR_W-1:0] latAddr;

  logic   grantValid;
  owner_t grantOwner;
  owner_t pickLast;
  logic   addrHit;
  logic   dataHit;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t lastOwner;
  assign pickLast = lastOwner;
`else
  assign pickLast = OWN_INST;
`endif

  arb_pick uPick (
    .instReq    (arbIf.inst_req),
    .dataReq    (arbIf.data_req),
    .lastOwner  (pickLast),
    .grantValid (grantValid),
    .grantOwner (grantOwner)
  );

  // Transaction FSM and grant-time payload capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_INST;
      latCmd  <= '0;
      latAddr <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastOwner <= OWN_INST;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            owner <= grantOwner;
`ifdef ARB_ROUND_ROBIN_EN
            lastOwner <= grantOwner;
`endif
            if (grantOwner == OWN_DATA) begin
              latCmd.wr    <= arbIf.data_wr;
              latCmd.size  <= arbIf.data_size;
              latCmd.wdata <= arbIf.data_wdata;
              latAddr      <= arbIf.data_addr;
            end else begin
              // instruction fetches are always word reads
              latCmd.wr    <= 1'b0;
              latCmd.size  <= SIZE_WORD;
              latCmd.wdata <= '0;
              latAddr      <= arbIf.inst_addr;
            end
            state <= ADDR;
          end
        end
        ADDR: begin
          // address and data may complete together
          if (arbIf.bus_addr_ok) begin
            state <= arbIf.bus_data_ok ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (arbIf.bus_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus drive and owner responses; everything is forced low while rst is high
  always_comb begin
    arbIf.inst_addr_ok = 1'b0;
    arbIf.inst_data_ok = 1'b0;
    arbIf.inst_rdata   = '0;
    arbIf.data_addr_ok = 1'b0;
    arbIf.data_data_ok = 1'b0;
    arbIf.data_rdata   = '0;
    arbIf.bus_req      = 1'b0;
    arbIf.bus_wr       = 1'b0;
    arbIf.bus_size     = '0;
    arbIf.bus_addr     = '0;
    arbIf.bus_wdata    = '0;
    busy               = 1'b0;
    addrHit            = 1'b0;
    dataHit            = 1'b0;

    if (!rst) begin
      busy = (state != IDLE);

      if (state == ADDR) begin
        arbIf.bus_req   = 1'b1;
        arbIf.bus_wr    = latCmd.wr;
        arbIf.bus_size  = latCmd.size;
        arbIf.bus_addr  = latAddr;
        arbIf.bus_wdata = latCmd.wdata;
        addrHit         = arbIf.bus_addr_ok;
        dataHit         = arbIf.bus_addr_ok & arbIf.bus_data_ok;
      end else if (state == WAIT) begin
        dataHit = arbIf.bus_data_ok;
      end

      arbIf.inst_addr_ok = addrHit & (owner == OWN_INST);
      arbIf.data_addr_ok = addrHit & (owner == OWN_DATA);
      arbIf.inst_data_ok = dataHit & (owner == OWN_INST);
      arbIf.data_data_ok = dataHit & (owner == OWN_DATA);

      if (dataHit && owner == OWN_INST) begin
        arbIf.inst_rdata = arbIf.bus_rdata;
      end
      if (dataHit && owner == OWN_DATA) begin
        arbIf.data_rdata = arbIf.bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push the expected
// bus command and owner responses into queues; a negedge monitor pops and
// compares whenever the arbiter presents a bus acceptance or a response pulse.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW = 32;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } busExp_t;

  typedef struct {
    logic        isData;  // 0: address-phase pulse, 1: data-phase pulse
    logic        owner;
    logic [31:0] rdata;
  } respExp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int testsRun  = 0;
  int failCount = 0;

  busExp_t  busQ[$];
  respExp_t respQ[$];

  mem_arbiter_if #(.ADDR_W(AW)) arbIf ();

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .arbIf (arbIf),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(string name);
    testsRun++;
    failCount++;
    $display("FAIL %s: event with empty scoreboard (t=%0t)", name, $time);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushBus(logic wr, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata);
    busExp_t e;
    e.wr = wr; e.size = size; e.addr = addr; e.wdata = wdata;
    busQ.push_back(e);
  endtask

  task automatic pushResp(logic isData, logic owner, logic [31:0] rdata);
    respExp_t r;
    r.isData = isData; r.owner = owner; r.rdata = rdata;
    respQ.push_back(r);
  endtask

  // Bus slave: wait for bus_req, optionally drop requests, then answer.
  task automatic serveBus(int addrWait, int dataWait, logic together,
                          logic [31:0] rd, logic [1:0] dropMask);
    int n = 0;
    while (!arbIf.bus_req && n < 20) begin
      tick();
      n++;
    end
    if (!arbIf.bus_req) begin
      unexpected("bus_req_timeout");
      return;
    end
    if (dropMask[0]) arbIf.inst_req = 1'b0;
    if (dropMask[1]) arbIf.data_req = 1'b0;
    repeat (addrWait) tick();
    arbIf.bus_addr_ok = 1'b1;
    if (together) begin
      arbIf.bus_data_ok = 1'b1;
      arbIf.bus_rdata   = rd;
    end
    tick();
    arbIf.bus_addr_ok = 1'b0;
    arbIf.bus_data_ok = 1'b0;
    arbIf.bus_rdata   = '0;
    if (!together) begin
      repeat (dataWait) tick();
      arbIf.bus_data_ok = 1'b1;
      arbIf.bus_rdata   = rd;
      tick();
      arbIf.bus_data_ok = 1'b0;
      arbIf.bus_rdata   = '0;
    end
  endtask

  // Monitor / scoreboard checker
  always @(negedge clk) begin
    busExp_t  e;
    respExp_t r;
    logic [1:0]  expPat;
    logic [63:0] expRd;

    if (arbIf.bus_req && arbIf.bus_addr_ok) begin
      if (busQ.size() == 0) begin
        unexpected("bus_accept");
      end else begin
        e = busQ.pop_front();
        check("bus_wr",    64'(arbIf.bus_wr),    64'(e.wr));
        check("bus_size",  64'(arbIf.bus_size),  64'(e.size));
        check("bus_addr",  64'(arbIf.bus_addr),  64'(e.addr));
        check("bus_wdata", 64'(arbIf.bus_wdata), 64'(e.wdata));
      end
    end

    if (arbIf.inst_addr_ok || arbIf.data_addr_ok) begin
      if (respQ.size() == 0) begin
        unexpected("addr_ok");
      end else begin
        r = respQ.pop_front();
        expPat = r.isData ? 2'b00 : (r.owner ? 2'b01 : 2'b10);
        check("addr_ok_owner", 64'({arbIf.inst_addr_ok, arbIf.data_addr_ok}), 64'(expPat));
      end
    end

    if (arbIf.inst_data_ok || arbIf.data_data_ok) begin
      if (respQ.size() == 0) begin
        unexpected("data_ok");
      end else begin
        r = respQ.pop_front();
        expPat = !r.isData ? 2'b00 : (r.owner ? 2'b01 : 2'b10);
        expRd  = r.owner ? {32'h0, r.rdata} : {r.rdata, 32'h0};
        check("data_ok_owner", 64'({arbIf.inst_data_ok, arbIf.data_data_ok}), 64'(expPat));
        check("rdata_route", {arbIf.inst_rdata, arbIf.data_rdata}, expRd);
      end
    end

    if (!arbIf.inst_data_ok) check("inst_rdata_zero", 64'(arbIf.inst_rdata), 64'h0);
    if (!arbIf.data_data_ok) check("data_rdata_zero", 64'(arbIf.data_rdata), 64'h0);
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", testsRun);
    $fatal(1, "watchdog expired");
  end

  initial begin
    arbIf.inst_req    = 1'b0;
    arbIf.inst_addr   = '0;
    arbIf.data_req    = 1'b0;
    arbIf.data_wr     = 1'b0;
    arbIf.data_size   = '0;
    arbIf.data_addr   = '0;
    arbIf.data_wdata  = '0;
    arbIf.bus_addr_ok = 1'b0;
    arbIf.bus_data_ok = 1'b0;
    arbIf.bus_rdata   = '0;

    // Reset with activity on the inputs: every output must stay 0
    rst = 1'b1;
    arbIf.inst_req    = 1'b1;
    arbIf.bus_addr_ok = 1'b1;
    arbIf.bus_data_ok = 1'b1;
    arbIf.bus_rdata   = 32'hFFFF_FFFF;
    tick();
    tick();
    @(negedge clk);
    check("reset_bus_out", {31'h0, arbIf.bus_req, arbIf.bus_wr, arbIf.bus_size, arbIf.bus_wdata},
          64'h0);
    check("reset_bus_addr", 64'(arbIf.bus_addr), 64'h0);
    check("reset_resp", 64'({arbIf.inst_addr_ok, arbIf.inst_data_ok, arbIf.data_addr_ok,
                              arbIf.data_data_ok, busy}), 64'h0);
    tick();
    arbIf.inst_req    = 1'b0;
    arbIf.bus_addr_ok = 1'b0;
    arbIf.bus_data_ok = 1'b0;
    arbIf.bus_rdata   = '0;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'h0);
    tick();

    // Instruction read: addr_ok in cycle 2, data_ok in cycle 4, busy 1..4
    arbIf.inst_req  = 1'b1;
    arbIf.inst_addr = 32'hBFC0_0000;
    pushBus(1'b0, SIZE_WORD, 32'hBFC0_0000, 32'h0);
    pushResp(1'b0, OWN_INST, 32'h0);
    pushResp(1'b1, OWN_INST, 32'h3C08_0001);
    @(negedge clk);
    check("c0_busy", 64'(busy), 64'h0);
    tick();
    arbIf.inst_req = 1'b0;
    @(negedge clk);
    check("c1_busy_busreq", 64'({busy, arbIf.bus_req}), 64'h3);
    tick();
    arbIf.bus_addr_ok = 1'b1;
    @(negedge clk);
    check("c2_busy", 64'(busy), 64'h1);
    tick();
    arbIf.bus_addr_ok = 1'b0;
    @(negedge clk);
    check("c3_busy_busreq", 64'({busy, arbIf.bus_req}), 64'h2);
    tick();
    arbIf.bus_data_ok = 1'b1;
    arbIf.bus_rdata   = 32'h3C08_0001;
    @(negedge clk);
    check("c4_busy", 64'(busy), 64'h1);
    tick();
    arbIf.bus_data_ok = 1'b0;
    arbIf.bus_rdata   = '0;
    @(negedge clk);
    check("c5_busy", 64'(busy), 64'h0);
    tick();

    // Data word read (leaves last grant with the data port)
    arbIf.data_req  = 1'b1;
    arbIf.data_wr   = 1'b0;
    arbIf.data_size = SIZE_WORD;
    arbIf.data_addr = 32'h0000_0040;
    arbIf.data_wdata = 32'h0;
    pushBus(1'b0, SIZE_WORD, 32'h0000_0040, 32'h0);
    pushResp(1'b0, OWN_DATA, 32'h0);
    pushResp(1'b1, OWN_DATA, 32'hA5A5_0001);
    serveBus(0, 2, 1'b0, 32'hA5A5_0001, 2'b10);
    tick();

    // Conflict: inst read at 0x100 vs data write 0xDEADBEEF at 0x200
    arbIf.inst_req   = 1'b1;
    arbIf.inst_addr  = 32'h0000_0100;
    arbIf.data_req   = 1'b1;
    arbIf.data_wr    = 1'b1;
    arbIf.data_size  = SIZE_WORD;
    arbIf.data_addr  = 32'h0000_0200;
    arbIf.data_wdata = 32'hDEAD_BEEF;
`ifdef ARB_ROUND_ROBIN_EN
    pushBus(1'b0, SIZE_WORD, 32'h0000_0100, 32'h0);
    pushResp(1'b0, OWN_INST, 32'h0);
    pushResp(1'b1, OWN_INST, 32'h0000_AAAA);
    pushBus(1'b1, SIZE_WORD, 32'h0000_0200, 32'hDEAD_BEEF);
    pushResp(1'b0, OWN_DATA, 32'h0);
    pushResp(1'b1, OWN_DATA, 32'h0000_BBBB);
    serveBus(0, 0, 1'b0, 32'h0000_AAAA, 2'b01);
    serveBus(0, 0, 1'b0, 32'h0000_BBBB, 2'b10);
`else
    pushBus(1'b1, SIZE_WORD, 32'h0000_0200, 32'hDEAD_BEEF);
    pushResp(1'b0, OWN_DATA, 32'h0);
    pushResp(1'b1, OWN_DATA, 32'h0000_AAAA);
    pushBus(1'b0, SIZE_WORD, 32'h0000_0100, 32'h0);
    pushResp(1'b0, OWN_INST, 32'h0);
    pushResp(1'b1, OWN_INST, 32'h0000_BBBB);
    serveBus(0, 0, 1'b0, 32'h0000_AAAA, 2'b10);
    serveBus(0, 0, 1'b0, 32'h0000_BBBB, 2'b01);
`endif
    tick();

    // Same-cycle completion: addr_ok and data_ok together in ADDR
    arbIf.data_req   = 1'b1;
    arbIf.data_wr    = 1'b0;
    arbIf.data_size  = SIZE_HALF;
    arbIf.data_addr  = 32'h0000_0302;
    arbIf.data_wdata = 32'h0;
    pushBus(1'b0, SIZE_HALF, 32'h0000_0302, 32'h0);
    pushResp(1'b0, OWN_DATA, 32'h0);
    pushResp(1'b1, OWN_DATA, 32'h0000_BEEF);
    serveBus(0, 0, 1'b1, 32'h0000_BEEF, 2'b10);
    @(negedge clk);
    check("together_idle", 64'({busy, arbIf.bus_req}), 64'h0);
    tick();

    // Stray bus_data_ok while IDLE is ignored
    arbIf.bus_data_ok = 1'b1;
    arbIf.bus_rdata   = 32'h0000_0077;
    @(negedge clk);
    check("idle_stray_data_ok", 64'({arbIf.inst_data_ok, arbIf.data_data_ok, busy}), 64'h0);
    tick();
    arbIf.bus_data_ok = 1'b0;
    arbIf.bus_rdata   = '0;

    // Hold stability: addr_ok withheld 5 cycles while data_addr moves
    arbIf.data_req   = 1'b1;
    arbIf.data_wr    = 1'b1;
    arbIf.data_size  = SIZE_BYTE;
    arbIf.data_addr  = 32'h0000_0400;
    arbIf.data_wdata = 32'hCAFE_F00D;
    pushBus(1'b1, SIZE_BYTE, 32'h0000_0400, 32'hCAFE_F00D);
    pushResp(1'b0, OWN_DATA, 32'h0);
    pushResp(1'b1, OWN_DATA, 32'h0);
    tick();
    arbIf.data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      arbIf.data_addr  = 32'h0000_0500 + 32'(i * 4);
      arbIf.data_wdata = 32'(i);
      // stray data_ok during ADDR without addr_ok must be ignored
      arbIf.bus_data_ok = (i == 2);
      @(negedge clk);
      check("hold_bus_addr", 64'(arbIf.bus_addr), 64'h0000_0400);
      check("hold_bus_wdata", 64'(arbIf.bus_wdata), 64'hCAFE_F00D);
      check("hold_no_data_ok", 64'({arbIf.bus_req, arbIf.data_data_ok}), 64'h2);
      tick();
      arbIf.bus_data_ok = 1'b0;
    end
    serveBus(0, 1, 1'b0, 32'h0, 2'b10);
    tick();

    // Reset while WAIT: transaction abandoned, late data_ok ignored
    arbIf.data_req   = 1'b1;
    arbIf.data_wr    = 1'b0;
    arbIf.data_size  = SIZE_WORD;
    arbIf.data_addr  = 32'h0000_0600;
    arbIf.data_wdata = 32'h0;
    pushBus(1'b0, SIZE_WORD, 32'h0000_0600, 32'h0);
    pushResp(1'b0, OWN_DATA, 32'h0);
    tick();
    arbIf.data_req    = 1'b0;
    arbIf.bus_addr_ok = 1'b1;
    tick();
    arbIf.bus_addr_ok = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_busy", 64'(busy), 64'h0);
    tick();
    rst = 1'b0;
    arbIf.bus_data_ok = 1'b1;
    arbIf.bus_rdata   = 32'h1234_5678;
    @(negedge clk);
    check("rst_late_data_ok", 64'({arbIf.data_data_ok, arbIf.inst_data_ok}), 64'h0);
    check("rst_late_busreq_busy", 64'({arbIf.bus_req, busy}), 64'h0);
    tick();
    arbIf.bus_data_ok = 1'b0;
    arbIf.bus_rdata   = '0;
    @(negedge clk);
    check("rst_after_busy", 64'(busy), 64'h0);
    tick();
    tick();

    check("bus_queue_drained", 64'(busQ.size()), 64'h0);
    check("resp_queue_drained", 64'(respQ.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of all address ports.
REQ-002 Ports:
  - clk  in  1  single clock; all state updates on rising edge.
  - rst  in  1  synchronous, active-high reset.
REQ-003 Instruction port:
  - inst_req  in  1
  - inst_addr  in  ADDR_W
  - inst_addr_ok  out  1
  - inst_data_ok  out  1
  - inst_rdata  out  32
REQ-004 Data port:
  - data_req  in  1
  - data_wr  in  1
  - data_size  in  2
  - data_addr  in  ADDR_W
  - data_wdata  in  32
  - data_addr_ok  out  1
  - data_data_ok  out  1
  - data_rdata  out  32
REQ-005 Bus port:
  - bus_req  out  1
  - bus_wr  out  1
  - bus_size  out  2
  - bus_addr  out  ADDR_W
  - bus_wdata  out  32
  - bus_addr_ok  in  1
  - bus_data_ok  in  1
  - bus_rdata  in  32
REQ-006 busy  out  1  high whenever state is not IDLE; the pipeline uses it as a stall source.

Function
REQ-007 FSM states SHALL be IDLE, ADDR and WAIT, with one outstanding bus transaction maximum.
REQ-008 In IDLE with any req high, the arbiter SHALL latch the winner's wr, size, addr and wdata plus an owner bit, then enter ADDR on the next edge; instruction grants force wr=0 and size=2'b10.
REQ-009 Default arbitration SHALL be fixed priority, data over instruction.
REQ-010 In ADDR, bus_req SHALL be 1 and bus_wr, bus_size, bus_addr and bus_wdata SHALL come from the latched registers, held stable until bus_addr_ok.
REQ-011 bus_addr_ok in ADDR SHALL pulse the owner's *_addr_ok in the same cycle (combinational) and move the FSM to WAIT.
REQ-012 bus_data_ok in WAIT SHALL pulse the owner's *_data_ok in the same cycle, pass bus_rdata to the owner's *_rdata, and return the FSM to IDLE.
REQ-013 bus_addr_ok and bus_data_ok both high in ADDR SHALL count as address and data completion together: both owner pulses fire and the FSM goes to IDLE.
REQ-014 bus_data_ok outside WAIT (and outside the REQ-013 case) SHALL be ignored.
REQ-015 The non-owner's addr_ok and data_ok SHALL always be 0; bus_req SHALL be 0 in IDLE and WAIT.
REQ-016 Minimum transaction latency: req in cycle N → bus_req in N+1 → earliest data_ok in N+1 (REQ-013), otherwise N+2.
REQ-017 A new grant SHALL only be taken in IDLE, so back-to-back transactions have a one-cycle IDLE gap.
REQ-018 A requester dropping req after its grant SHALL NOT cancel the transaction.
REQ-019 *_rdata SHALL be 0 when the corresponding data_ok is 0.

Reset
REQ-020 rst SHALL force state IDLE, owner=0, last_owner=0 and all latched payload registers to 0.
REQ-021 During and after rst, every output SHALL be 0.
REQ-022 rst mid-transaction SHALL abandon the transaction, with no addr_ok or data_ok pulse to either requester afterwards; any late bus_data_ok is ignored per REQ-014.

Configuration
REQ-023 With ARB_ROUND_ROBIN_EN defined, when both req are high in IDLE the grant SHALL go to the port not granted last (last_owner register, updated at each grant).
REQ-024 Without ARB_ROUND_ROBIN_EN, fixed data priority SHALL apply and the last_owner register SHALL NOT exist.

Structure
REQ-025 A shared definitions package SHALL hold the state encoding (IDLE/ADDR/WAIT), the owner codes (OWN_INST=0, OWN_DATA=1) and the size codes (byte=0, half=1, word=2).
REQ-026 One sub-module, arb_pick, SHALL be combinational: inputs are the two reqs and last_owner; outputs are grant_valid and grant_owner. All other logic stays in mem_arbiter.

Verification
REQ-027 Instruction read: inst_req=1, inst_addr=0xBFC00000; bus_addr_ok in cycle 2, bus_data_ok with rdata=0x3C080001 in cycle 4 → inst_addr_ok in cycle 2, inst_data_ok plus inst_rdata=0x3C080001 in cycle 4, busy 1..4.
REQ-028 Conflict: both req high at 0x100 (inst) and 0x200 (data write, wdata=0xDEADBEEF).
  - Without macro: bus_addr=0x200 with bus_wr=1 first, then 0x100.
  - With macro, after a prior data grant: 0x100 first.
REQ-029 Same-cycle completion: bus_addr_ok and bus_data_ok high together in ADDR → both data_addr_ok and data_data_ok pulse, next cycle is IDLE with busy=0.
REQ-030 Reset in WAIT: data transaction outstanding, rst for 1 cycle, then bus_data_ok=1 → data_data_ok stays 0, bus_req=0, busy=0.
REQ-031 Hold stability: bus_addr_ok withheld 5 cycles while data_addr changes after grant → bus_addr stays the latched value for all 5 cycles.
